// File: rtl/fetch_seq_if.sv
// fetch_seq_if: sequencer control inputs, memory read data and fetch/decode/execute status outputs.
interface fetch_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              enable;
    logic              load;
    logic              halt;
    logic [ADDR_W-1:0] nxt_adr;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] crnt_adr;
    logic [DATA_W-1:0] instr;
    logic              fetch;
    logic              decode;
    logic              execute;
    logic              halted;
    modport master (
        output enable, load, halt, nxt_adr, mem_data,
        input  crnt_adr, instr, fetch, decode, execute, halted
    );
    modport slave (
        input  enable, load, halt, nxt_adr, mem_data,
        output crnt_adr, instr, fetch, decode, execute, halted
    );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: fetch/decode/execute instruction sequencer with jump and halt, one-hot registered phase outputs.
module fetch_seq #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int RESET_ADR   = 0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_seq_if.slave   bus
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
    localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADR);
    localparam logic [1:0]        LAST  = 2'(EXEC_CYCLES - 1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_instr;
    logic [1:0]        r_cnt;
    logic [3:0]        r_ph;
    logic              w_last;
    assign w_last       = r_cnt == LAST;
    assign bus.crnt_adr = r_adr;
    assign bus.instr    = r_instr;
    assign {bus.halted, bus.execute, bus.decode, bus.fetch} = r_ph;
    // r_ph is loaded with the one-hot code of the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_adr   <= RST_A;
            r_instr <= '0;
            r_cnt   <= '0;
            r_ph    <= 4'b0001;
        end else if (bus.enable) begin
            case (r_state)
                FETCH: begin
                    r_instr <= bus.mem_data;
                    r_adr   <= r_adr + 1'b1;
                    r_state <= DECODE;
                    r_ph    <= 4'b0010;
                end
                DECODE: begin
                    r_cnt   <= '0;
                    r_state <= EXEC;
                    r_ph    <= 4'b0100;
                end
                EXEC: begin
                    if (w_last) begin
                        if (bus.load) r_adr <= bus.nxt_adr;
                        r_state <= bus.halt ? HALT : FETCH;
                        r_ph    <= bus.halt ? 4'b1000 : 4'b0001;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: two sequencers (EXEC_CYCLES=1/RESET_ADR=0 and EXEC_CYCLES=3/RESET_ADR=63) checked against an instruction-period model.
module tb_fetch_seq;
    logic clk = 0;
    logic rst, en, ld, hl;
    logic [5:0] na;
    logic [7:0] mem [64];
    always #5 clk = ~clk;

    fetch_seq_if #(.ADDR_W(6), .DATA_W(8)) b0 ();
    fetch_seq_if #(.ADDR_W(6), .DATA_W(8)) b1 ();
    assign b0.enable = en;
    assign b0.load = ld;
    assign b0.halt = hl;
    assign b0.nxt_adr = na;
    assign b0.mem_data = mem[b0.crnt_adr];
    assign b1.enable = en;
    assign b1.load = ld;
    assign b1.halt = hl;
    assign b1.nxt_adr = na;
    assign b1.mem_data = mem[b1.crnt_adr];

    fetch_seq #(.ADDR_W(6), .DATA_W(8), .EXEC_CYCLES(1), .RESET_ADR(0))
        u0 (.clk(clk), .reset(rst), .bus(b0.slave));
    fetch_seq #(.ADDR_W(6), .DATA_W(8), .EXEC_CYCLES(3), .RESET_ADR(63))
        u1 (.clk(clk), .reset(rst), .bus(b1.slave));

    int tests = 0;
    int fails = 0;
    int ec [2] = '{1, 3};
    int ra [2] = '{0, 63};
    int pos [2];
    int pc [2];
    int ir [2];
    bit hm [2];
    int ex_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pos counts cycles into the instruction period: 0 fetch, 1 decode, 2.. execute
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pos[d] = 0; pc[d] = ra[d]; ir[d] = 0; hm[d] = 0;
            end else if (en && !hm[d]) begin
                if (pos[d] == 0) begin
                    ir[d] = int'(mem[pc[d]]); pc[d] = (pc[d] + 1) % 64; pos[d] = 1;
                end else if (pos[d] == ec[d] + 1) begin
                    if (ld) pc[d] = int'(na);
                    if (hl) hm[d] = 1;
                    pos[d] = 0;
                end else begin
                    pos[d]++;
                end
            end
        end
    endtask

    task automatic check();
        chk("u0.adr", 32'(b0.crnt_adr), pc[0]);
        chk("u0.instr", 32'(b0.instr), ir[0]);
        chk("u0.phase", {28'd0, b0.halted, b0.execute, b0.decode, b0.fetch},
            {28'd0, hm[0], !hm[0] && pos[0] >= 2, !hm[0] && pos[0] == 1, !hm[0] && pos[0] == 0});
        chk("u1.adr", 32'(b1.crnt_adr), pc[1]);
        chk("u1.instr", 32'(b1.instr), ir[1]);
        chk("u1.phase", {28'd0, b1.halted, b1.execute, b1.decode, b1.fetch},
            {28'd0, hm[1], !hm[1] && pos[1] >= 2, !hm[1] && pos[1] == 1, !hm[1] && pos[1] == 0});
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        #1;
        check();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
        rst = 1; en = 1; ld = 0; hl = 0; na = 0;
        cyc();
        chk("rst.u0.fetch", 32'(b0.fetch), 1);
        chk("rst.u1.adr", 32'(b1.crnt_adr), 63);
        rst = 0;
        ex_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ex_cnt += int'(b1.execute);
            if (i == 0) begin
                chk("wrap.u1.adr", 32'(b1.crnt_adr), 0);
                chk("wrap.u1.instr", 32'(b1.instr), 32'(mem[63]));
            end
        end
        chk("exec3.count", ex_cnt, 3);
        chk("exec3.period", 32'(b1.fetch), 1);
        for (int i = 0; i < 7; i++) cyc();
        chk("seq.u0.instr", 32'(b0.instr), 4);
        chk("seq.u0.adr", 32'(b0.crnt_adr), 4);
        for (int k = 0; k < 8 && pos[0] != 2; k++) cyc();
        ld = 1; na = 40;
        cyc();
        ld = 0;
        chk("jump.u0.adr", 32'(b0.crnt_adr), 40);
        cyc();
        chk("jump.u0.instr", 32'(b0.instr), 32'(mem[40]));
        ld = 1; na = 20;
        cyc();
        ld = 0;
        cyc();
        chk("ignore.u0.adr", 32'(b0.crnt_adr), 41);
        for (int k = 0; k < 8 && pos[1] != 3; k++) cyc();
        en = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("freeze.u1.exec", 32'(b1.execute), 1);
        en = 1;
        hl = 1; ld = 1; na = 9;
        for (int k = 0; k < 12 && !(hm[0] && hm[1]); k++) cyc();
        hl = 0; ld = 1; na = 5;
        for (int i = 0; i < 4; i++) cyc();
        ld = 0;
        chk("halt.u0", {b0.halted, 2'd0, b0.crnt_adr}, {1'b1, 2'd0, 6'd9});
        chk("halt.u1", {b1.halted, 2'd0, b1.crnt_adr}, {1'b1, 2'd0, 6'd9});
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_halt.u1", {b1.fetch, b1.halted, b1.crnt_adr, b1.instr}, {2'b10, 6'd63, 8'd0});
        for (int k = 0; k < 8 && pos[1] != 3; k++) cyc();
        rst = 1; ld = 1; hl = 1; en = 0;
        cyc();
        rst = 0; ld = 0; hl = 0; en = 1;
        chk("rst_exec.u1", {b1.fetch, b1.execute, b1.crnt_adr, b1.instr}, {2'b10, 6'd63, 8'd0});
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 9) != 0;
            ld = $urandom_range(0, 3) == 0;
            hl = $urandom_range(0, 40) == 0;
            rst = $urandom_range(0, 60) == 0;
            na = 6'($urandom);
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
